// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-fetch
// side (32-bit) and a data side (64-bit), with a per-transaction timeout.
//
// state  | meaning
// IDLE   | no transaction; sample requests, grant one at the next edge
// BUSY_I | instruction request presented on the memory port
// BUSY_D | data request presented on the memory port
// RESP   | one-cycle done pulse (with err_o) to the granted side
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_done_o,
    output logic [31:0] i_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [63:0] d_addr_i,
    input  logic [63:0] d_wdata_i,
    output logic        d_done_o,
    output logic [63:0] d_rdata_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic       last_d_q;
    logic [7:0] cnt_q;

    // The memory-port output registers double as the latched request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            cnt_q       <= '0;
            i_done_o    <= 1'b0;
            d_done_o    <= 1'b0;
            i_rdata_o   <= '0;
            d_rdata_o   <= '0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req_i && (!d_req_i || last_d_q)) begin
                        state_q     <= BUSY_I;
                        last_d_q    <= 1'b0;
                        cnt_q       <= '0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= {32'h0, i_addr_i};
                        mem_wdata_o <= '0;
                    end else if (d_req_i) begin
                        state_q     <= BUSY_D;
                        last_d_q    <= 1'b1;
                        cnt_q       <= '0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (!mem_ready_i) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                    // A ready arriving on the timeout cycle still counts as success.
                    if (mem_ready_i || (cnt_q == CNT_LAST)) begin
                        state_q     <= RESP;
                        i_done_o    <= (state_q == BUSY_I);
                        d_done_o    <= (state_q == BUSY_D);
                        err_o       <= !mem_ready_i;
                        d_rdata_o   <= mem_ready_i ? mem_rdata_i : 64'h0;
                        i_rdata_o   <= mem_ready_i ? mem_rdata_i[31:0] : 32'h0;
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    i_done_o  <= 1'b0;
                    d_done_o  <= 1'b0;
                    err_o     <= 1'b0;
                    i_rdata_o <= '0;
                    d_rdata_o <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;
    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_done_o;
    logic [31:0] i_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [63:0] d_addr_i;
    logic [63:0] d_wdata_i;
    logic        d_done_o;
    logic [63:0] d_rdata_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [63:0] mem_rdata_i;
    logic        mem_ready_i;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_done_o(i_done_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_done_o(d_done_o), .d_rdata_o(d_rdata_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: one transaction in flight (or its response), plus the
    // side that won most recently.
    bit          m_busy = 0;
    bit          m_resp = 0;
    bit          m_side_d = 0;
    bit          m_last_d = 1;
    bit          m_we = 0;
    bit          m_err = 0;
    logic [63:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic [63:0] m_data = '0;
    int          m_waited = 0;

    task automatic model_edge();
        if (!rst_ni) begin
            m_busy = 0; m_resp = 0; m_last_d = 1; m_err = 0; m_data = '0; m_waited = 0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            m_waited++;
            if (mem_ready_i) begin
                m_busy = 0; m_resp = 1; m_err = 0; m_data = mem_rdata_i;
            end else if (m_waited == TIMEOUT) begin
                m_busy = 0; m_resp = 1; m_err = 1; m_data = '0;
            end
        end else if (i_req_i || d_req_i) begin
            m_side_d = (i_req_i && d_req_i) ? !m_last_d : d_req_i;
            m_last_d = m_side_d;
            m_busy   = 1;
            m_waited = 0;
            m_we     = m_side_d ? d_we_i : 1'b0;
            m_addr   = m_side_d ? d_addr_i : {32'h0, i_addr_i};
            m_wdata  = m_side_d ? d_wdata_i : 64'h0;
        end
    endtask

    // Advance one clock, update the model with the inputs seen at the edge,
    // then compare every output #1 later.
    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        chk("mem_req", 64'(mem_req_o), 64'(m_busy));
        chk("mem_we", 64'(mem_we_o), 64'(m_busy && m_we));
        chk("mem_addr", mem_addr_o, m_busy ? m_addr : 64'h0);
        chk("mem_wdata", mem_wdata_o, m_busy ? m_wdata : 64'h0);
        chk("i_done", 64'(i_done_o), 64'(m_resp && !m_side_d));
        chk("d_done", 64'(d_done_o), 64'(m_resp && m_side_d));
        chk("err", 64'(err_o), 64'(m_resp && m_err));
        chk("i_rdata", 64'(i_rdata_o), m_resp ? {32'h0, m_data[31:0]} : 64'h0);
        chk("d_rdata", d_rdata_o, m_resp ? m_data : 64'h0);
    endtask

    int busy_seen;
    int lat;
    int cnt;

    initial begin
        rst_ni = 0; i_req_i = 0; i_addr_i = '0; d_req_i = 0; d_we_i = 0;
        d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = '0; mem_ready_i = 0;
        repeat (3) step();
        chk("lit_rst_req", 64'(mem_req_o), 64'h0);
        rst_ni = 1;

        // Single load
        d_req_i = 1; d_addr_i = 64'h40; mem_ready_i = 1; mem_rdata_i = 64'hDEADBEEF_00000013;
        step();
        chk("lit_ld_grant", 64'(mem_req_o), 64'h1);
        chk("lit_ld_addr", mem_addr_o, 64'h40);
        step();
        chk("lit_ld_done", 64'(d_done_o), 64'h1);
        chk("lit_ld_rdata", d_rdata_o, 64'hDEADBEEF_00000013);
        chk("lit_ld_err", 64'(err_o), 64'h0);
        d_req_i = 0; mem_ready_i = 0;
        step();
        chk("lit_ld_pulse", 64'(d_done_o), 64'h0);

        // Contention right after reset: I, D, I, D
        rst_ni = 0; step(); rst_ni = 1;
        i_req_i = 1; i_addr_i = 32'h8000_1234;
        d_req_i = 1; d_addr_i = 64'h0000_0001_0000_0100;
        mem_ready_i = 1; mem_rdata_i = 64'hCAFEF00D_12345678;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("lit_arb_grant", mem_addr_o,
                (k % 2 == 0) ? 64'h0000_0000_8000_1234 : 64'h0000_0001_0000_0100);
            step();
            chk("lit_arb_done", 64'((k % 2 == 0) ? i_done_o : d_done_o), 64'h1);
            if (k % 2 == 0) chk("lit_arb_irdata", 64'(i_rdata_o), 64'h12345678);
            step();
        end
        i_req_i = 0; d_req_i = 0; mem_ready_i = 0;
        step();

        // Store, ready on the 4th busy cycle
        d_req_i = 1; d_we_i = 1; d_addr_i = 64'h8; d_wdata_i = 64'h1122334455667788;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("lit_st_we", 64'(mem_we_o), 64'h1);
            chk("lit_st_wdata", mem_wdata_o, 64'h1122334455667788);
        end
        mem_ready_i = 1;
        step();
        chk("lit_st_done", 64'(d_done_o), 64'h1);
        d_req_i = 0; d_we_i = 0; mem_ready_i = 0;
        step();

        // Timeout
        i_req_i = 1; i_addr_i = 32'h100; cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (mem_req_o) cnt++;
            if (i_done_o) break;
        end
        chk("lit_to_cycles", 64'(cnt), 64'd16);
        chk("lit_to_done", 64'(i_done_o), 64'h1);
        chk("lit_to_err", 64'(err_o), 64'h1);
        chk("lit_to_rdata", 64'(i_rdata_o), 64'h0);
        i_req_i = 0;
        step();

        // Reset on the 2nd busy cycle
        i_req_i = 1; i_addr_i = 32'h200;
        step(); step();
        rst_ni = 0;
        step();
        chk("lit_rb_req", 64'(mem_req_o), 64'h0);
        chk("lit_rb_done", 64'(i_done_o), 64'h0);
        rst_ni = 1;
        step();
        chk("lit_rb_regrant", mem_addr_o, 64'h200);
        mem_ready_i = 1;
        step();
        chk("lit_rb_done2", 64'(i_done_o), 64'h1);
        i_req_i = 0; mem_ready_i = 0;
        step();

        // Randomized traffic
        busy_seen = 0; lat = 1;
        for (int c = 0; c < 4000; c++) begin
            if (i_req_i && i_done_o) i_req_i = 0;
            else if (!i_req_i && $urandom_range(3, 0) == 0) begin
                i_req_i = 1; i_addr_i = $urandom();
            end
            if (d_req_i && d_done_o) d_req_i = 0;
            else if (!d_req_i && $urandom_range(3, 0) == 0) begin
                d_req_i = 1; d_we_i = ($urandom_range(1, 0) == 1);
                d_addr_i = {$urandom(), $urandom()}; d_wdata_i = {$urandom(), $urandom()};
            end
            if (mem_req_o) begin
                busy_seen++;
                mem_ready_i = (busy_seen >= lat);
            end else begin
                busy_seen = 0;
                lat = $urandom_range(20, 1);
                mem_ready_i = ($urandom_range(1, 0) == 1);
            end
            mem_rdata_i = {$urandom(), $urandom()};
            rst_ni = ($urandom_range(199, 0) != 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
